nmos_beam_counter: RTL and testbench

//  Horizontal/vertical beam counter: the source of the beam-position bus that compare cells sample.

---
 rtl/nmos_beam_pkg.sv | 20 ++
 rtl/nmos_beam_window.sv | 42 ++++
 rtl/nmos_beam_counter.sv | 114 +++++++++++
 tb/tb_nmos_beam_counter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nmos_beam_pkg.sv
// Beam counter timing constants (PAL long frame) and counter widths shared by
// the counter top and its window decoders.
package nmos_beam_pkg;

  localparam int HW = 9;
  localparam int VW = 11;

  localparam int H_TOTAL  = 227;
  localparam int V_TOTAL  = 313;

  localparam int HS_START = 18;
  localparam int HS_STOP  = 35;
  localparam int HB_START = 217;
  localparam int HB_STOP  = 40;

  localparam int VS_START = 2;
  localparam int VS_STOP  = 5;
  localparam int VB_STOP  = 25;

endpackage

// File: rtl/nmos_beam_window.sv
// Registered window decoder: active while pos is in [START, STOP), or outside
// [STOP, START) when the window wraps through zero.
module nmos_beam_window #(
  parameter int       W          = 9,
  parameter int       START      = 0,
  parameter int       STOP       = 1,
  parameter bit       WRAP       = 1'b0,
  parameter bit       RST_ACTIVE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pos,
  output logic         active
);

  localparam logic [W-1:0] START_V  = W'(START);
  localparam logic [W-1:0] STOP_V   = W'(STOP);
  localparam logic [W-1:0] SPAN_IN  = W'(STOP - START);
  localparam logic [W-1:0] SPAN_OUT = W'(START - STOP);

  logic [W-1:0] off;
  logic         hit;

  // Offset-and-span form keeps a single unsigned compare and handles a zero start.
  always_comb begin
    off = '0;
    hit = 1'b0;
    if (WRAP) begin
      off = pos - STOP_V;
      hit = !(off < SPAN_OUT);
    end else begin
      off = pos - START_V;
      hit = (off < SPAN_IN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) active <= RST_ACTIVE;
    else     active <= hit;
  end

endmodule

// File: rtl/nmos_beam_counter.sv
// Horizontal/vertical beam counter with interlace LOF, CPU position writes,
// registered sync/blank windows and end-of-line/frame strobes.
module nmos_beam_counter
  import nmos_beam_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          C1,
  input  logic          LACE,
  input  logic [15:0]   DB,
  input  logic          WR_H,
  input  logic          WR_V,
  output logic [HW-1:0] HPOS,
  output logic [VW-1:0] VPOS,
  output logic          LOF,
  output logic          HSYNC_n,
  output logic          VSYNC_n,
  output logic          HBLANK,
  output logic          VBLANK,
  output logic          EOL,
  output logic          EOF
);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST_LONG  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST_SHORT = VW'(V_TOTAL - 2);

  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d, v_last;
  logic          lof_q, lof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic          line_step;
  logic          hsync_act, hblank_act, vsync_act, vblank_act;
  logic          db_unused;

  assign db_unused = ^DB[14:VW];

  // Writes override counting per axis; a V write still lets H wrap normally.
  always_comb begin
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    lof_d     = lof_q;
    eol_d     = 1'b0;
    eof_d     = 1'b0;
    line_step = 1'b0;
    v_last    = lof_q ? V_LAST_LONG : V_LAST_SHORT;

    if (WR_H) begin
      hpos_d = DB[HW-1:0];
    end else if (C1) begin
      if (hpos_q >= H_LAST) begin
        hpos_d    = '0;
        eol_d     = 1'b1;
        line_step = 1'b1;
      end else begin
        hpos_d = hpos_q + HW'(1);
      end
    end

    if (WR_V) begin
      vpos_d = DB[VW-1:0];
      lof_d  = DB[15];
    end else if (line_step) begin
      if (vpos_q >= v_last) begin
        vpos_d = '0;
        eof_d  = 1'b1;
        lof_d  = LACE ? ~lof_q : 1'b1;
      end else begin
        vpos_d = vpos_q + VW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hpos_q <= '0;
      vpos_q <= '0;
      lof_q  <= 1'b1;
      eol_q  <= 1'b0;
      eof_q  <= 1'b0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      lof_q  <= lof_d;
      eol_q  <= eol_d;
      eof_q  <= eof_d;
    end
  end

  // Windows decode the next-state positions so they line up with HPOS/VPOS.
  nmos_beam_window #(.W(HW), .START(HS_START), .STOP(HS_STOP), .WRAP(1'b0), .RST_ACTIVE(1'b0))
    u_hsync (.clk(CLK), .rst(RST), .pos(hpos_d), .active(hsync_act));

  nmos_beam_window #(.W(HW), .START(HB_START), .STOP(HB_STOP), .WRAP(1'b1), .RST_ACTIVE(1'b1))
    u_hblank (.clk(CLK), .rst(RST), .pos(hpos_d), .active(hblank_act));

  nmos_beam_window #(.W(VW), .START(VS_START), .STOP(VS_STOP), .WRAP(1'b0), .RST_ACTIVE(1'b0))
    u_vsync (.clk(CLK), .rst(RST), .pos(vpos_d), .active(vsync_act));

  nmos_beam_window #(.W(VW), .START(0), .STOP(VB_STOP), .WRAP(1'b0), .RST_ACTIVE(1'b1))
    u_vblank (.clk(CLK), .rst(RST), .pos(vpos_d), .active(vblank_act));

  assign HPOS    = hpos_q;
  assign VPOS    = vpos_q;
  assign LOF     = lof_q;
  assign EOL     = eol_q;
  assign EOF     = eof_q;
  assign HSYNC_n = ~hsync_act;
  assign VSYNC_n = ~vsync_act;
  assign HBLANK  = hblank_act;
  assign VBLANK  = vblank_act;

endmodule

// File: tb/tb_nmos_beam_counter.sv
// Directed bench for nmos_beam_counter: reset, line/frame counting, interlace,
// C1 gating, position writes and sync/blank decodes.
module tb_nmos_beam_counter;

  logic        CLK;
  logic        RST;
  logic        C1;
  logic        LACE;
  logic [15:0] DB;
  logic        WR_H;
  logic        WR_V;
  logic [8:0]  HPOS;
  logic [10:0] VPOS;
  logic        LOF;
  logic        HSYNC_n;
  logic        VSYNC_n;
  logic        HBLANK;
  logic        VBLANK;
  logic        EOL;
  logic        EOF;

  int errors = 0;
  int checks = 0;

  nmos_beam_counter dut (
    .CLK(CLK), .RST(RST), .C1(C1), .LACE(LACE), .DB(DB), .WR_H(WR_H), .WR_V(WR_V),
    .HPOS(HPOS), .VPOS(VPOS), .LOF(LOF), .HSYNC_n(HSYNC_n), .VSYNC_n(VSYNC_n),
    .HBLANK(HBLANK), .VBLANK(VBLANK), .EOL(EOL), .EOF(EOF)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // driver: apply inputs, take one edge, sample 1ns later, drop write strobes
  task automatic step(input logic c1, input logic wh, input logic wv, input logic [15:0] db);
    C1 = c1; WR_H = wh; WR_V = wv; DB = db;
    @(posedge CLK);
    #1;
    WR_H = 1'b0; WR_V = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; C1 = 1'b0; LACE = 1'b0; DB = '0; WR_H = 1'b0; WR_V = 1'b0;
    step(0, 0, 0, 16'd0);
    step(0, 0, 0, 16'd0);
    RST = 1'b0;
    step(0, 0, 0, 16'd0);
    step(0, 1, 1, 16'd100);
    checks++; if (HPOS !== 9'd100) begin errors++; $display("FAIL pre_rst_hpos: got %0d expected 100", HPOS); end
    checks++; if (HBLANK !== 1'b0) begin errors++; $display("FAIL pre_rst_hblank: got %0b expected 0", HBLANK); end
    C1 = 1'b1;
    #2 RST = 1'b1;
    #1;
    checks++; if (HPOS !== 9'd0) begin errors++; $display("FAIL rst_hpos: got %0d expected 0", HPOS); end
    checks++; if (VPOS !== 11'd0) begin errors++; $display("FAIL rst_vpos: got %0d expected 0", VPOS); end
    checks++; if (LOF !== 1'b1) begin errors++; $display("FAIL rst_lof: got %0b expected 1", LOF); end
    checks++; if ({HSYNC_n, VSYNC_n, HBLANK, VBLANK} !== 4'b1111) begin errors++;
      $display("FAIL rst_sync_blank: got %b expected 1111", {HSYNC_n, VSYNC_n, HBLANK, VBLANK}); end
    checks++; if ({EOL, EOF} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b expected 00", {EOL, EOF}); end
    @(posedge CLK); #1;
    checks++; if (HPOS !== 9'd0) begin errors++; $display("FAIL rst_hold_hpos: got %0d expected 0", HPOS); end
    C1 = 1'b0;
    RST = 1'b0;
  endtask

  task automatic test_hcount();
    int gap;
    int hs_low;
    int hb_high;
    for (int i = 0; i < 226; i++) step(1, 0, 0, 16'd0);
    checks++; if (HPOS !== 9'd226) begin errors++; $display("FAIL h226_hpos: got %0d expected 226", HPOS); end
    checks++; if (EOL !== 1'b0) begin errors++; $display("FAIL h226_eol: got %0b expected 0", EOL); end
    step(1, 0, 0, 16'd0);
    checks++; if (HPOS !== 9'd0) begin errors++; $display("FAIL hwrap_hpos: got %0d expected 0", HPOS); end
    checks++; if (EOL !== 1'b1) begin errors++; $display("FAIL hwrap_eol: got %0b expected 1", EOL); end
    checks++; if (VPOS !== 11'd1) begin errors++; $display("FAIL hwrap_vpos: got %0d expected 1", VPOS); end
    gap = 0; hs_low = 0; hb_high = 0;
    do begin
      step(1, 0, 0, 16'd0);
      gap++;
      if (HSYNC_n === 1'b0) hs_low++;
      if (HBLANK === 1'b1) hb_high++;
    end while (EOL !== 1'b1 && gap < 400);
    checks++; if (gap !== 227) begin errors++; $display("FAIL eol_period: got %0d expected 227", gap); end
    checks++; if (hs_low !== 17) begin errors++; $display("FAIL hsync_width: got %0d expected 17", hs_low); end
    checks++; if (hb_high !== 50) begin errors++; $display("FAIL hblank_width: got %0d expected 50", hb_high); end
    checks++; if (VPOS !== 11'd2) begin errors++; $display("FAIL line2_vpos: got %0d expected 2", VPOS); end
  endtask

  task automatic test_c1_toggle();
    int exp_h;
    int h_bad;
    int sync_bad;
    int eol_c1;
    int eol_c0;
    int hs_tick;
    int hs_clk;
    logic c1;
    logic exp_hs_n;
    logic exp_hb;
    step(0, 1, 0, 16'd0);
    exp_h = 0; h_bad = 0; sync_bad = 0; eol_c1 = 0; eol_c0 = 0; hs_tick = 0; hs_clk = 0;
    for (int i = 0; i < 454; i++) begin
      c1 = (i % 2 == 0);
      step(c1, 0, 0, 16'd0);
      if (c1) exp_h = (exp_h == 226) ? 0 : exp_h + 1;
      exp_hs_n = !(exp_h >= 18 && exp_h < 35);
      exp_hb   = (exp_h >= 217 || exp_h < 40);
      if (HPOS !== 9'(exp_h)) h_bad++;
      if (HSYNC_n !== exp_hs_n || HBLANK !== exp_hb) sync_bad++;
      if (EOL === 1'b1) begin if (c1) eol_c1++; else eol_c0++; end
      if (HSYNC_n === 1'b0) begin hs_clk++; if (c1) hs_tick++; end
    end
    checks++; if (h_bad !== 0) begin errors++; $display("FAIL toggle_hpos: got %0d bad samples expected 0", h_bad); end
    checks++; if (sync_bad !== 0) begin errors++; $display("FAIL toggle_decode: got %0d bad samples expected 0", sync_bad); end
    checks++; if (eol_c1 !== 1) begin errors++; $display("FAIL toggle_eol_c1: got %0d expected 1", eol_c1); end
    checks++; if (eol_c0 !== 0) begin errors++; $display("FAIL toggle_eol_c0: got %0d expected 0", eol_c0); end
    checks++; if (hs_tick !== 17) begin errors++; $display("FAIL toggle_hsync_ticks: got %0d expected 17", hs_tick); end
    checks++; if (hs_clk !== 34) begin errors++; $display("FAIL toggle_hsync_clks: got %0d expected 34", hs_clk); end
  endtask

  task automatic test_frame_lace0();
    LACE = 1'b0;
    step(0, 0, 1, 16'h8138);
    step(0, 1, 0, 16'd226);
    checks++; if (VPOS !== 11'd312 || LOF !== 1'b1 || HPOS !== 9'd226) begin errors++;
      $display("FAIL l0_setup: got v=%0d lof=%0b h=%0d expected v=312 lof=1 h=226", VPOS, LOF, HPOS); end
    step(1, 0, 0, 16'd0);
    checks++; if ({HPOS, VPOS, EOL, EOF, LOF} !== {9'd0, 11'd0, 3'b111}) begin errors++;
      $display("FAIL l0_eof_long: got h=%0d v=%0d eol=%0b eof=%0b lof=%0b expected 0 0 1 1 1", HPOS, VPOS, EOL, EOF, LOF); end
    checks++; if (VSYNC_n !== 1'b1 || VBLANK !== 1'b1) begin errors++;
      $display("FAIL l0_vdecode0: got vs_n=%0b vb=%0b expected 1 1", VSYNC_n, VBLANK); end
    step(1, 0, 0, 16'd0);
    checks++; if ({EOL, EOF} !== 2'b00 || HPOS !== 9'd1) begin errors++;
      $display("FAIL l0_strobe_pulse: got eol=%0b eof=%0b h=%0d expected 0 0 1", EOL, EOF, HPOS); end
    step(0, 0, 1, 16'h0137);
    step(0, 1, 0, 16'd226);
    step(1, 0, 0, 16'd0);
    checks++; if ({VPOS, EOF, LOF} !== {11'd0, 2'b11}) begin errors++;
      $display("FAIL l0_eof_short: got v=%0d eof=%0b lof=%0b expected 0 1 1", VPOS, EOF, LOF); end
  endtask

  task automatic test_frame_lace1();
    LACE = 1'b1;
    step(0, 0, 1, 16'h8138);
    step(0, 1, 0, 16'd226);
    step(1, 0, 0, 16'd0);
    checks++; if ({VPOS, EOF, LOF} !== {11'd0, 2'b10}) begin errors++;
      $display("FAIL l1_long_end: got v=%0d eof=%0b lof=%0b expected 0 1 0", VPOS, EOF, LOF); end
    step(0, 0, 1, 16'h0136);
    step(0, 1, 0, 16'd226);
    step(1, 0, 0, 16'd0);
    checks++; if ({VPOS, EOF, LOF} !== {11'd311, 2'b00}) begin errors++;
      $display("FAIL l1_short_310: got v=%0d eof=%0b lof=%0b expected 311 0 0", VPOS, EOF, LOF); end
    step(0, 1, 0, 16'd226);
    step(1, 0, 0, 16'd0);
    checks++; if ({VPOS, EOF, LOF} !== {11'd0, 2'b11}) begin errors++;
      $display("FAIL l1_short_end: got v=%0d eof=%0b lof=%0b expected 0 1 1", VPOS, EOF, LOF); end
    step(0, 0, 1, 16'h8137);
    step(0, 1, 0, 16'd226);
    step(1, 0, 0, 16'd0);
    checks++; if ({VPOS, EOF, LOF} !== {11'd312, 2'b01}) begin errors++;
      $display("FAIL l1_long_311: got v=%0d eof=%0b lof=%0b expected 312 0 1", VPOS, EOF, LOF); end
    LACE = 1'b0;
  endtask

  task automatic test_vdecode();
    step(0, 0, 1, 16'd1);
    step(0, 1, 0, 16'd226);
    step(1, 0, 0, 16'd0);
    checks++; if ({VPOS, VSYNC_n, VBLANK} !== {11'd2, 2'b01}) begin errors++;
      $display("FAIL vsync_start: got v=%0d vs_n=%0b vb=%0b expected 2 0 1", VPOS, VSYNC_n, VBLANK); end
    step(0, 0, 1, 16'd4);
    checks++; if (VSYNC_n !== 1'b0) begin errors++; $display("FAIL vsync_4: got %0b expected 0", VSYNC_n); end
    step(0, 1, 0, 16'd226);
    step(1, 0, 0, 16'd0);
    checks++; if ({VPOS, VSYNC_n} !== {11'd5, 1'b1}) begin errors++;
      $display("FAIL vsync_stop: got v=%0d vs_n=%0b expected 5 1", VPOS, VSYNC_n); end
    step(0, 0, 1, 16'd24);
    checks++; if (VBLANK !== 1'b1) begin errors++; $display("FAIL vblank_24: got %0b expected 1", VBLANK); end
    step(0, 0, 1, 16'd25);
    checks++; if (VBLANK !== 1'b0) begin errors++; $display("FAIL vblank_25: got %0b expected 0", VBLANK); end
  endtask

  task automatic test_writes();
    step(0, 1, 0, 16'd226);
    step(1, 0, 1, 16'h8136);
    checks++; if ({HPOS, EOL, VPOS, LOF, EOF} !== {9'd0, 1'b1, 11'd310, 2'b10}) begin errors++;
      $display("FAIL wrv_at_wrap: got h=%0d eol=%0b v=%0d lof=%0b eof=%0b expected 0 1 310 1 0", HPOS, EOL, VPOS, LOF, EOF); end
    step(0, 0, 1, 16'd7);
    step(0, 1, 0, 16'd300);
    checks++; if ({HPOS, HBLANK, EOL, VPOS} !== {9'd300, 2'b10, 11'd7}) begin errors++;
      $display("FAIL wrh_300: got h=%0d hb=%0b eol=%0b v=%0d expected 300 1 0 7", HPOS, HBLANK, EOL, VPOS); end
    step(1, 0, 0, 16'd0);
    checks++; if ({HPOS, EOL, VPOS} !== {9'd0, 1'b1, 11'd8}) begin errors++;
      $display("FAIL wrh_300_wrap: got h=%0d eol=%0b v=%0d expected 0 1 8", HPOS, EOL, VPOS); end
    step(1, 1, 0, 16'd50);
    checks++; if ({HPOS, EOL} !== {9'd50, 1'b0}) begin errors++;
      $display("FAIL wrh_priority: got h=%0d eol=%0b expected 50 0", HPOS, EOL); end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'd0);
    checks++; if ({HPOS, EOL, VPOS} !== {9'd50, 1'b0, 11'd8}) begin errors++;
      $display("FAIL c1_hold: got h=%0d eol=%0b v=%0d expected 50 0 8", HPOS, EOL, VPOS); end
    step(1, 1, 1, 16'h0064);
    checks++; if ({HPOS, VPOS, LOF} !== {9'd100, 11'd100, 1'b0}) begin errors++;
      $display("FAIL both_writes: got h=%0d v=%0d lof=%0b expected 100 100 0", HPOS, VPOS, LOF); end
  endtask

  initial begin
    test_reset();
    test_hcount();
    test_c1_toggle();
    test_frame_lace0();
    test_frame_lace1();
    test_vdecode();
    test_writes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
